// File: rtl/fir_pkg.sv
// Shared FIR parameters for the tap sequencer, delay-line RAM and coeff ROM.
// Order_MSB sizes addresses/tap indices, ADC_MSB sizes signed samples.
package fir_pkg;

  localparam int Order_MSB = 5;
  localparam int ADC_MSB   = 11;
  localparam int Order     = 39;

  typedef enum logic [1:0] {
    FLUSH,
    IDLE,
    RUN
  } seq_state_t;

endpackage

// File: rtl/fir_tap_sequencer.sv
// Delay-line sequencer: zero-flushes the RAM, then per sample walks 0..Order
// shifting the line and streaming taps x[n-k] with index k to the MAC.
// Ports: clk, reset (sync, high); sample_valid/sample_in/ready accept samples;
// overrun_clr/overrun sticky drop flag; buf_* drive the delay-line RAM;
// tap_valid/first/last/index/data stream taps; done pulses after tap_last.
module fir_tap_sequencer
  import fir_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sample_valid,
  input  logic signed [ADC_MSB:0] sample_in,
  input  logic                  overrun_clr,
  output logic                  ready,
  output logic [Order_MSB:0]    buf_address,
  output logic signed [ADC_MSB:0] buf_wr_data,
  input  logic signed [ADC_MSB:0] buf_rd_data,
  output logic                  tap_valid,
  output logic                  tap_first,
  output logic                  tap_last,
  output logic [Order_MSB:0]    tap_index,
  output logic signed [ADC_MSB:0] tap_data,
  output logic                  done,
  output logic                  overrun
);

  localparam logic [Order_MSB:0] LastCnt =
    (Order_MSB + 1)'(Order);

  if (Order >= 2 ** (Order_MSB + 1)) begin : g_order_chk
    $error("Order does not fit in Order_MSB+1 bits");
  end

  seq_state_t             r_state;
  seq_state_t             w_state_nx;
  logic [Order_MSB:0]     r_cnt;
  logic [Order_MSB:0]     w_cnt_nx;
  logic signed [ADC_MSB:0] r_sample;
  logic signed [ADC_MSB:0] w_sample_nx;
  logic                   r_done;
  logic                   w_done_nx;
  logic                   r_overrun;
  logic                   w_drop;

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_sample_nx = r_sample;
    w_done_nx   = 1'b0;
    ready       = 1'b0;
    // RAM always writes; park on the dead word with zero data.
    buf_address = LastCnt;
    buf_wr_data = '0;
    tap_valid   = 1'b0;
    tap_first   = 1'b0;
    tap_last    = 1'b0;
    tap_index   = '0;
    tap_data    = '0;
    unique case (r_state)
      FLUSH: begin
        buf_address = r_cnt;
        if (r_cnt == LastCnt) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      IDLE: begin
        ready = 1'b1;
        if (sample_valid) begin
          w_sample_nx = sample_in;
          w_cnt_nx    = '0;
          w_state_nx  = RUN;
        end
      end
      RUN: begin
        buf_address = r_cnt;
        tap_valid   = 1'b1;
        tap_index   = r_cnt;
        tap_first   = (r_cnt == '0);
        tap_last    = (r_cnt == LastCnt);
        // Read data is the pre-write word at k-1: writing it at k shifts.
        tap_data    = (r_cnt == '0) ? r_sample : buf_rd_data;
        buf_wr_data = tap_data;
        if (r_cnt == LastCnt) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
          w_done_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nx = FLUSH;
        w_cnt_nx   = '0;
      end
    endcase
  end

  assign w_drop = sample_valid & ~ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= FLUSH;
      r_cnt     <= '0;
      r_sample  <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_sample  <= w_sample_nx;
      r_done    <= w_done_nx;
      // A new drop beats a simultaneous clear.
      r_overrun <= w_drop | (r_overrun & ~overrun_clr);
    end
  end

  assign done    = r_done;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer with a behavioural read-before-write RAM.
// Expected taps come from a history queue of accepted samples.
module tb_fir_tap_sequencer;
  import fir_pkg::*;

  localparam int AW = Order_MSB + 1;
  localparam int DW = ADC_MSB + 1;

  logic clk = 1'b0;
  logic reset;
  logic sample_valid;
  logic overrun_clr;
  logic signed [DW-1:0] sample_in;
  logic signed [DW-1:0] buf_wr_data;
  logic signed [DW-1:0] buf_rd_data;
  logic signed [DW-1:0] tap_data;
  logic ready, tap_valid, tap_first, tap_last, done, overrun;
  logic [AW-1:0] buf_address, tap_index;

  logic signed [DW-1:0] mem [0:Order];
  logic scramble;

  logic signed [DW-1:0] hist [$];
  int n_cmp = 0;
  int n_bad = 0;
  bit exp_ovr;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .overrun_clr  (overrun_clr),
    .ready        (ready),
    .buf_address  (buf_address),
    .buf_wr_data  (buf_wr_data),
    .buf_rd_data  (buf_rd_data),
    .tap_valid    (tap_valid),
    .tap_first    (tap_first),
    .tap_last     (tap_last),
    .tap_index    (tap_index),
    .tap_data     (tap_data),
    .done         (done),
    .overrun      (overrun)
  );

  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i <= Order; i++)
        mem[i] <= DW'($urandom);
    end else begin
      buf_rd_data <= mem[buf_address];
      mem[buf_address] <= buf_wr_data;
    end
  end

  task automatic test_reset(input bit scr);
    int nz;
    reset = 1'b1;
    scramble = scr;
    sample_valid = 1'b0;
    overrun_clr = 1'b0;
    @(negedge clk);
    scramble = 1'b0;
    reset = 1'b0;
    n_cmp++;
    if (ready !== 1'b0 || tap_valid !== 1'b0 || done !== 1'b0 ||
        overrun !== 1'b0 || tap_first !== 1'b0 || tap_last !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got rdy=%b tv=%b done=%b ovr=%b want all 0",
               ready, tap_valid, done, overrun);
    end
    hist.delete();
    exp_ovr = 1'b0;
    for (int c = 0; c <= Order; c++) begin
      n_cmp++;
      if (buf_address !== AW'(c) || buf_wr_data !== '0 ||
          ready !== 1'b0 || done !== 1'b0 || tap_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL flush c=%0d got addr=%0d wd=%0d rdy=%b done=%b want addr=%0d wd=0",
                 c, buf_address, buf_wr_data, ready, done, c);
      end
      @(negedge clk);
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_ready got %b want 1", ready);
    end
    nz = 0;
    for (int i = 0; i <= Order; i++)
      if (mem[i] !== '0) nz++;
    n_cmp++;
    if (nz != 0) begin
      n_bad++;
      $display("FAIL flush_ram got %0d nonzero words want 0", nz);
    end
  endtask

  task automatic run_frame(input logic signed [DW-1:0] s,
                           input int drop_a, input int drop_b,
                           input int clr_at, input int abort_at);
    logic signed [DW-1:0] e;
    int w;
    w = 0;
    while (ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL ready_timeout got %b want 1", ready);
      return;
    end
    sample_valid = 1'b1;
    sample_in = s;
    overrun_clr = 1'b0;
    hist.push_front(s);
    for (int k = 0; k <= Order; k++) begin
      @(negedge clk);
      e = (k < hist.size()) ? hist[k] : '0;
      n_cmp++;
      if (tap_valid !== 1'b1 || tap_index !== AW'(k) || tap_data !== e ||
          buf_address !== AW'(k) || buf_wr_data !== e ||
          tap_first !== (k == 0) || tap_last !== (k == Order) ||
          done !== 1'b0 || ready !== 1'b0 || overrun !== exp_ovr) begin
        n_bad++;
        $display("FAIL tap k=%0d got v=%b idx=%0d d=%0d a=%0d wd=%0d f=%b l=%b dn=%b r=%b o=%b want d=%0d o=%b",
                 k, tap_valid, tap_index, tap_data, buf_address, buf_wr_data,
                 tap_first, tap_last, done, ready, overrun, e, exp_ovr);
      end
      if (k == abort_at) begin
        sample_valid = 1'b0;
        return;
      end
      sample_valid = (k == drop_a) || (k == drop_b);
      sample_in = DW'($urandom);
      overrun_clr = (k == clr_at);
      if (sample_valid) exp_ovr = 1'b1;
      else if (overrun_clr) exp_ovr = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b1 || ready !== 1'b1 || tap_valid !== 1'b0 ||
        overrun !== exp_ovr) begin
      n_bad++;
      $display("FAIL frame_end got done=%b rdy=%b tv=%b o=%b want 1 1 0 %b",
               done, ready, tap_valid, overrun, exp_ovr);
    end
    sample_valid = 1'b0;
    overrun_clr = 1'b0;
  endtask

  task automatic test_impulse();
    run_frame(12'sd100, -1, -1, -1, -1);
    for (int n = 1; n <= Order + 1; n++)
      run_frame('0, -1, -1, -1, -1);
  endtask

  task automatic test_ramp();
    test_reset(1'b0);
    for (int n = 0; n < 20; n++)
      run_frame(DW'(n + 1), -1, -1, -1, -1);
  endtask

  task automatic test_overrun();
    run_frame(DW'($urandom), 20, Order, -1, -1);
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_bad++;
      $display("FAIL overrun_set got %b want 1", overrun);
    end
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    exp_ovr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_bad++;
      $display("FAIL overrun_clr got %b want 0", overrun);
    end
    n_cmp++;
    if (done !== 1'b0) begin
      n_bad++;
      $display("FAIL done_single got %b want 0", done);
    end
  endtask

  task automatic test_same_cycle();
    run_frame(DW'($urandom), 5, 10, 10, -1);
    run_frame(DW'($urandom), -1, -1, 30, -1);
  endtask

  task automatic test_abort();
    run_frame(DW'($urandom), -1, -1, -1, 15);
    test_reset(1'b0);
    run_frame(DW'($urandom), -1, -1, -1, -1);
    run_frame(DW'($urandom), -1, -1, -1, -1);
  endtask

  task automatic test_random();
    int da, db, ca;
    for (int n = 0; n < 10; n++) begin
      da = ($urandom_range(3) == 0) ? int'($urandom_range(Order)) : -1;
      db = ($urandom_range(3) == 0) ? int'($urandom_range(Order)) : -1;
      ca = ($urandom_range(2) == 0) ? int'($urandom_range(Order)) : -1;
      run_frame(DW'($urandom), da, db, ca, -1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    scramble = 1'b0;
    sample_valid = 1'b0;
    overrun_clr = 1'b0;
    sample_in = '0;
    exp_ovr = 1'b0;
    @(negedge clk);
    test_reset(1'b1);
    test_impulse();
    test_ramp();
    test_overrun();
    test_same_cycle();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Sequences the read-before-write delay-line RAM of the FIR filter: one RAM per filter, Order+1 words, ADC_MSB+1 bits, registered read and unconditional write every clk.
- On each accepted ADC sample it walks addresses 0..Order. This shifts the delay line one place and streams the Order+1 tap samples, with tap indices, to the coefficient ROM / MAC stage.
- It also zero-flushes the RAM after reset and flags samples that arrive while it is busy.

Parameters:
- Order_MSB, 5, MSB of address and tap index; Order must be less than 2**(Order_MSB+1).
- ADC_MSB, 11, MSB of signed sample words.
- Order, 39, filter order; the block produces Order+1 taps per sample.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe: new ADC sample present.
- sample_in  in  ADC_MSB+1 signed  ADC sample.
- overrun_clr  in  1  clears the sticky overrun flag.
- ready  out  1  high only in IDLE; a sample is accepted when sample_valid and ready are both high.
- buf_address  out  Order_MSB+1  delay-line RAM address.
- buf_wr_data  out  ADC_MSB+1 signed  RAM write data (current_bits).
- buf_rd_data  in  ADC_MSB+1 signed  RAM registered read data (previous cycle's address).
- tap_valid  out  1  tap_data and tap_index are valid this cycle.
- tap_first  out  1  with tap_valid, marks tap 0 (MAC clear/load).
- tap_last  out  1  with tap_valid, marks tap Order.
- tap_index  out  Order_MSB+1  coefficient index k.
- tap_data  out  ADC_MSB+1 signed  x[n-k].
- done  out  1  one-cycle pulse the cycle after tap_last.
- overrun  out  1  sticky flag: a sample was dropped.

Behaviour:
- The RAM writes buf_wr_data at buf_address on every clk and has no enable. Outside FLUSH/RUN the block parks buf_address at Order with buf_wr_data = 0; word Order is dead storage and is never used as a tap.
- States are FLUSH, IDLE and RUN, with a counter cnt of Order_MSB+1 bits.
- Reset (any state, mid-frame included): state <= FLUSH, cnt <= 0, overrun <= 0; ready, tap_valid, tap_first, tap_last and done <= 0. An aborted frame produces no done.
- FLUSH: buf_address = cnt, buf_wr_data = 0. cnt counts 0..Order (Order+1 cycles), then state goes to IDLE. ready stays low.
- IDLE: ready = 1. On sample_valid, capture sample_in into sample_reg, set cnt <= 0, go to RUN.
- RUN, cnt = k:
  - buf_address = k, tap_index = k, tap_valid = 1.
  - k = 0: buf_wr_data = tap_data = sample_reg.
  - k > 0: buf_wr_data = tap_data = buf_rd_data, which is the old word k-1.
  - tap_first = (k == 0); tap_last = (k == Order).
  - At k = Order: go to IDLE and pulse done in the next cycle.
- tap_* outputs are combinational from state, cnt and buf_rd_data; done and overrun are registered.
- Latency: sample accepted at cycle T gives tap 0 at T+1, tap Order at T+Order+1, done and ready = 1 at T+Order+2. Minimum sample period is Order+2 clocks.
- Overrun:
  - sample_valid while ready = 0 (FLUSH or RUN, including the tap_last cycle) drops the sample and sets overrun; the current frame continues unaffected.
  - overrun_clr clears overrun. If overrun_clr and a new drop occur in the same cycle, set wins.
- tap_data is passed through at full width with no arithmetic; the MAC owns growth and rounding.
- Elaboration check: Order < 2**(Order_MSB+1).

Decomposition:
- Package fir_pkg holds the shared parameters used by this block, the delay-line RAM and the coefficient ROM (Order_MSB, ADC_MSB, Order) and the state enum {FLUSH, IDLE, RUN}.
- No sub-module: counter and FSM are one process. The bench instantiates the existing delay-line RAM alongside this block.

Test Plan:
- Reset, then watch flush → addresses 0..39 are written with 0 over 40 cycles, ready rises at cycle 41, and every RAM word reads 0.
- Impulse: sample 100 then 40 zero-samples, each with ready → tap_data is 100 at tap_index 0 for frame 0, tap_index 1 for frame 1, and so on; all other taps are 0; frame 40 is all zero.
- Ramp 1,2,3,... at the minimum period of 41 clocks → at frame n, tap k = n+1-k for k ≤ n, else 0; exactly one done per frame, 41 cycles after acceptance.
- sample_valid asserted at tap_index 20 and again on the tap_last cycle → both samples dropped, overrun = 1, taps of the running frame unchanged; overrun_clr → 0.
- Reset at tap_index 15 of a frame → no done pulse, full 40-cycle flush runs, and the next sample yields tap 0 = sample and taps 1..39 = 0.
- Same-cycle overrun_clr and drop → overrun stays 1.
